// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy irrigation engine: FSM states, config map,
// reset-default thresholds and rule consequents.
package fuzzy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FUZZ = 3'd1,
    ST_RULE = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int NUM_RULES = 18;
  localparam int NUM_THR   = 8;

  // Config address map (5-bit space)
  localparam logic [4:0] ADDR_SOIL_DRY   = 5'd0;
  localparam logic [4:0] ADDR_SOIL_MOIST = 5'd1;
  localparam logic [4:0] ADDR_SOIL_WET   = 5'd2;
  localparam logic [4:0] ADDR_TEMP_COLD  = 5'd3;
  localparam logic [4:0] ADDR_TEMP_WARM  = 5'd4;
  localparam logic [4:0] ADDR_TEMP_HOT   = 5'd5;
  localparam logic [4:0] ADDR_RAIN_NO    = 5'd6;
  localparam logic [4:0] ADDR_RAIN_YES   = 5'd7;
  localparam logic [4:0] ADDR_CONS_BASE  = 5'd8;
  localparam logic [4:0] ADDR_CONS_LAST  = 5'd25;

  // Thresholds in address order: soil dry/moist/wet, temp cold/warm/hot, rain no/yes
  localparam int unsigned DEF_THR [NUM_THR] = '{400, 600, 800, 300, 500, 700, 100, 400};

  // Consequent seconds, indexed by r = soil*6 + temp*2 + rain
  localparam int unsigned DEF_CONS [NUM_RULES] = '{
    0, 0, 10, 0, 45, 0,
    0, 0, 10, 0, 45, 0,
    0, 0, 10, 0, 30, 0
  };

endpackage

// File: rtl/fuzzy_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle over WIDTH cycles.
// The start cycle performs the first step directly from the inputs, so the
// quotient is complete on the edge where done is high. WIDTH must be >= 2.
module fuzzy_seq_divider #(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, rem_n, quo_n, cur_rem, cur_quo;
  logic [WIDTH:0]   shifted, diff;
  logic [CW-1:0]    cnt;
  logic             fits;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    cur_rem = start ? '0 : rem;
    cur_quo = start ? dividend : quo;
    shifted = {cur_rem, cur_quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = ~diff[WIDTH];
    rem_n   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_n   = {cur_quo[WIDTH-2:0], fits};
  end

  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign quotient = quo;

  // Step counter and working registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start || busy) begin
      rem <= rem_n;
      quo <= quo_n;
      if (start) begin
        cnt  <= CW'(1);
        busy <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fuzzy_irrigation_engine.sv
// Fuzzy irrigation controller: fuzzify three sensors, evaluate 18 min-rules
// into a weighted sum, defuzzify with a sequential divider.
// Optional feature macro FUZZY_RAIN_OVERRIDE_EN: force irrigation_time to 0
// whenever rain is reported present.
module fuzzy_irrigation_engine
  import fuzzy_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] soil_digital,
  input  logic [DATA_WIDTH-1:0] dht11_digital,
  input  logic [DATA_WIDTH-1:0] rain_digital,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_rej,
  output logic [OUT_WIDTH-1:0]  irrigation_time,
  output logic                  rain_present
);

  localparam int NUM_W = DATA_WIDTH + OUT_WIDTH + 5;
  localparam int DEN_W = DATA_WIDTH + 5;
  localparam logic [DATA_WIDTH-1:0] MU_MAX = '1;

  state_t state;

  logic [DATA_WIDTH-1:0] thr  [NUM_THR];
  logic [OUT_WIDTH-1:0]  cons [NUM_RULES];

  logic [DATA_WIDTH-1:0] soil_l, temp_l, rain_l;
  logic [2:0][DATA_WIDTH-1:0] soil_mu, temp_mu;
  logic [1:0][DATA_WIDTH-1:0] rain_mu;

  logic [4:0]       rule_idx;
  logic [1:0]       si, ti;
  logic             ri;
  logic [DATA_WIDTH-1:0] w;
  logic [DATA_WIDTH+OUT_WIDTH-1:0] prod;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;

  logic             div_start, div_busy, div_done;
  logic [NUM_W-1:0] div_quo;
  logic [OUT_WIDTH-1:0] defuzz;
  logic             rain_wet;

  // Truncated (d * MU_MAX) / span; span is positive whenever the compare
  // chain selects a ramp, the zero guard only covers unselected evaluation.
  function automatic logic [DATA_WIDTH-1:0] ramp(input logic [DATA_WIDTH-1:0] d,
                                                 input logic [DATA_WIDTH-1:0] span);
    logic [2*DATA_WIDTH-1:0] p;
    p = {{DATA_WIDTH{1'b0}}, d} * {{DATA_WIDTH{1'b0}}, MU_MAX};
    if (span == '0) return '0;
    return DATA_WIDTH'(p / {{DATA_WIDTH{1'b0}}, span});
  endfunction

  // Three-set membership {top, mid, low}; compare order keeps spans positive
  function automatic logic [3*DATA_WIDTH-1:0] fuzz3(input logic [DATA_WIDTH-1:0] x, a, b, c);
    logic [DATA_WIDTH-1:0] m0, m1, m2;
    m0 = '0; m1 = '0; m2 = '0;
    if (x <= a) m0 = MU_MAX;
    else if (x <= b) begin
      m0 = ramp(b - x, b - a);
      m1 = ramp(x - a, b - a);
    end else if (x <= c) begin
      m1 = ramp(c - x, c - b);
      m2 = ramp(x - b, c - b);
    end else m2 = MU_MAX;
    return {m2, m1, m0};
  endfunction

  // Two-set membership {yes, no}
  function automatic logic [2*DATA_WIDTH-1:0] fuzz2(input logic [DATA_WIDTH-1:0] x, a, b);
    logic [DATA_WIDTH-1:0] m0, m1;
    m0 = '0; m1 = '0;
    if (x <= a) m0 = MU_MAX;
    else if (x <= b) begin
      m0 = ramp(b - x, b - a);
      m1 = ramp(x - a, b - a);
    end else m1 = MU_MAX;
    return {m1, m0};
  endfunction

  assign busy = (state != ST_IDLE);

  // Rule strength and weighted consequent for the current rule index
  always_comb begin
    si   = 2'(rule_idx / 5'd6);
    ti   = 2'((rule_idx >> 1) % 5'd3);
    ri   = rule_idx[0];
    w    = (soil_mu[si] < temp_mu[ti]) ? soil_mu[si] : temp_mu[ti];
    w    = (rain_mu[ri] < w) ? rain_mu[ri] : w;
    prod = {{OUT_WIDTH{1'b0}}, w} * {{DATA_WIDTH{1'b0}}, cons[rule_idx]};
  end

  // Defuzzified value: empty rule base gives 0, oversize quotient saturates
  always_comb begin
    if (den == '0)                        defuzz = '0;
    else if (|div_quo[NUM_W-1:OUT_WIDTH]) defuzz = '1;
    else                                  defuzz = div_quo[OUT_WIDTH-1:0];
    rain_wet = (rain_l >= thr[ADDR_RAIN_YES[2:0]]);
  end

  // Divider kicks off on the first DIV cycle; it is idle exactly then
  assign div_start = (state == ST_DIV) && !div_busy;

  fuzzy_seq_divider #(.WIDTH(NUM_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (num),
    .divisor  ({{OUT_WIDTH{1'b0}}, den}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Inference sequencer: latch, fuzzify, accumulate rules, divide, publish
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      done            <= 1'b0;
      irrigation_time <= '0;
      rain_present    <= 1'b0;
      num             <= '0;
      den             <= '0;
      rule_idx        <= '0;
      soil_l          <= '0;
      temp_l          <= '0;
      rain_l          <= '0;
      soil_mu         <= '0;
      temp_mu         <= '0;
      rain_mu         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          soil_l   <= soil_digital;
          temp_l   <= dht11_digital;
          rain_l   <= rain_digital;
          num      <= '0;
          den      <= '0;
          rule_idx <= '0;
          state    <= ST_FUZZ;
        end
        ST_FUZZ: begin
          soil_mu <= fuzz3(soil_l, thr[0], thr[1], thr[2]);
          temp_mu <= fuzz3(temp_l, thr[3], thr[4], thr[5]);
          rain_mu <= fuzz2(rain_l, thr[6], thr[7]);
          state   <= ST_RULE;
        end
        ST_RULE: begin
          num <= num + {5'd0, prod};
          den <= den + {5'd0, w};
          if (rule_idx == 5'(NUM_RULES - 1)) state <= ST_DIV;
          else rule_idx <= rule_idx + 1'b1;
        end
        ST_DIV: if (div_done) state <= ST_DONE;
        ST_DONE: begin
          rain_present <= rain_wet;
`ifdef FUZZY_RAIN_OVERRIDE_EN
          irrigation_time <= rain_wet ? '0 : defuzz;
`else
          irrigation_time <= defuzz;
`endif
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Config registers: writable only while idle; mapped writes while busy are
  // dropped and flagged. Consequents keep the low OUT_WIDTH bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_rej <= 1'b0;
      for (int i = 0; i < NUM_THR; i++)   thr[i]  <= DATA_WIDTH'(DEF_THR[i]);
      for (int i = 0; i < NUM_RULES; i++) cons[i] <= OUT_WIDTH'(DEF_CONS[i]);
    end else begin
      cfg_rej <= 1'b0;
      if (cfg_we) begin
        if (state == ST_IDLE) begin
          if (cfg_addr < ADDR_CONS_BASE)
            thr[cfg_addr[2:0]] <= cfg_wdata;
          else if (cfg_addr <= ADDR_CONS_LAST)
            cons[cfg_addr - ADDR_CONS_BASE] <= cfg_wdata[OUT_WIDTH-1:0];
        end else if (cfg_addr <= ADDR_CONS_LAST) begin
          cfg_rej <= 1'b1;
        end
      end
    end
  end

endmodule
